fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the five-stage pipeline. It owns the PC and drives the byte address of the combinational instruction ROM, which has word index addr[ADDR_WIDTH-1:2]. Fetched words go into a 2-entry {pc, insn} FIFO toward IF/ID over a valid/ready handshake. It also handles branch/jump redirects, halt/resume and misaligned-target faults.

Parameters:
ADDR_WIDTH, 9, byte-address width of PC and instruction memory
INSN_WIDTH, 32, instruction word width
RESET_PC, 0, PC loaded at reset (must be 4-byte aligned)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
imem_addr  out  ADDR_WIDTH  byte address to instruction memory (= pc_q)
imem_insn  in  INSN_WIDTH  combinational read data for imem_addr
out_valid  out  1  FIFO head valid toward decode
out_ready  in  1  decode accepts head this cycle
out_pc  out  ADDR_WIDTH  PC of head entry
out_insn  out  INSN_WIDTH  instruction of head entry
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  ADDR_WIDTH  redirect target
halt_req  in  1  level; stop fetching while high
halted  out  1  state == HALT
fault  out  1  sticky misaligned-redirect flag
fault_pc  out  ADDR_WIDTH  offending redirect_pc

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC; FIFO empty (count=0, rd/wr ptr=0); state=BOOT; out_valid=0, out_pc=0, out_insn=0, halted=0, fault=0, fault_pc=0.
- FSM: BOOT -> RUN on the first clock after reset release. This is one cycle with no fetch.
- RUN -> HALT when halt_req=1.
- HALT -> RUN when halt_req=0.
- Any state -> FAULT on a misaligned redirect. FAULT is left only by reset.
- pop = out_valid & out_ready.
- push = (state==RUN) & ~halt_req & ~redirect_valid & (count<2 | pop).
- Push writes {pc_q, imem_insn} at the tail, and pc_q <= pc_q + 4, wrapping modulo 2^ADDR_WIDTH (0x1FC -> 0x000 at default width).
- Latency: a word sampled at cycle N is visible on out_* at cycle N+1. Steady state with out_ready=1 is one instruction per cycle.
- Push and pop in the same cycle leave count unchanged. A full FIFO with pop=1 still pushes.
- Out_* show the head entry. When the FIFO is empty, out_pc and out_insn hold their last value and out_valid=0.
- Redirect (redirect_valid=1, redirect_pc[1:0]==0), in any state except FAULT/BOOT:
  - the FIFO is flushed (count=0) and pc_q <= redirect_pc; there is no push that cycle;
  - a pop in the same cycle completes (the consumer owns that word), then the flush applies;
  - a redirect in HALT updates pc_q and flushes; the state stays HALT.
- Misaligned redirect (redirect_pc[1:0]!=0): fault=1, fault_pc=redirect_pc, FIFO flushed, state=FAULT, pc_q unchanged. In FAULT, out_valid=0 and there is no push; further redirects are ignored.
- Halt stops pushes only. Buffered entries still drain to decode.
- halted=1 exactly while state==HALT (registered).
- imem_addr = pc_q at all times, including HALT and FAULT.
- Reset asserted mid-operation discards FIFO contents immediately and asynchronously.

Decomposition:
- Package fetch_pkg holds:
  - state enum fetch_state_e {BOOT, RUN, HALT, FAULT};
  - constant INSN_BYTES=4;
  - struct fetch_entry_t {pc, insn}, parameterised through package localparams matching the defaults.
- One sub-module: fetch_fifo2, a 2-entry synchronous FIFO with a flush input, count/full/empty outputs and async active-low reset. The top level holds the FSM, PC and fault logic.

Test Plan:
- Reset release, out_ready=1, ROM word i = 0x1000_0000+i -> cycle 1 BOOT with no push. out_valid rises at cycle 3 with out_pc=0x000 and out_insn=0x10000000, then 0x004/0x10000001 and so on, one per cycle.
- out_ready=0 for 5 cycles -> count saturates at 2, pc_q stops at 0x008 and out_pc holds 0x000. When ready returns, entries 0x000, 0x004 and 0x008 are delivered in order with no gap.
- Redirect to 0x040 while the FIFO holds 2 entries and a pop occurs -> the popped entry is delivered, the other is discarded, and the next out_pc is 0x040 two cycles later.
- halt_req held 4 cycles with out_ready=1 -> the FIFO drains, halted=1 and imem_addr is frozen. Release resumes at the frozen pc with halted=0 one cycle later.
- PC at 0x1F8 free-running -> entries 0x1F8, 0x1FC, 0x000.
- Redirect to 0x042 -> fault=1, fault_pc=0x042, out_valid=0 forever. A later redirect to 0x000 is ignored. Asserting rst_n=0 mid-cycle clears fault and out_valid immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e : sequencer FSM states (BOOT, RUN, HALT, FAULT)
//   INSN_BYTES    : byte stride between consecutive instruction words
//   fetch_entry_t : {pc, insn} pair held in the fetch FIFO at default widths
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int ADDR_W     = 9;
    localparam int INSN_W     = 32;
    localparam int INSN_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// -----------------------------------------------------------------------------
// fetch_fifo2
// Two-entry synchronous FIFO with flush, used between fetch and decode.
// The head is presented from a register so that, once the FIFO runs empty,
// rd_data keeps showing the last head instead of whatever stale slot the
// read pointer lands on.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/pop   : write tail / retire head (pop ignored when empty,
//                push accepted when not full or when popping the same cycle)
//   flush      : empty the FIFO after this cycle's pop; push must be low
//   wr_data    : tail write data
//   rd_data    : head entry (holds last value while empty)
//   count      : number of valid entries (0..2)
//   full/empty : count == 2 / count == 0
// -----------------------------------------------------------------------------
module fetch_fifo2 #(
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;

    logic             do_push;
    logic             do_pop;
    logic [1:0]       count_nx;
    logic             rd_ptr_nx;
    logic             wr_ptr_nx;
    logic [WIDTH-1:0] head_nx;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    always_comb begin
        do_pop    = pop & ~empty;
        do_push   = push & (~full | do_pop);
        count_nx  = count + {1'b0, do_push} - {1'b0, do_pop};
        rd_ptr_nx = rd_ptr ^ do_pop;
        wr_ptr_nx = wr_ptr ^ do_push;
        if (flush) begin
            count_nx  = 2'd0;
            rd_ptr_nx = 1'b0;
            wr_ptr_nx = 1'b0;
        end
        // Next head: the word being written this cycle if it lands in the
        // slot the read pointer moves to, otherwise the stored slot.
        head_nx = rd_data;
        if (count_nx != 2'd0) begin
            if (do_push && (wr_ptr == rd_ptr_nx)) begin
                head_nx = wr_data;
            end else begin
                head_nx = mem[rd_ptr_nx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_data <= '0;
        end else begin
            count   <= count_nx;
            rd_ptr  <= rd_ptr_nx;
            wr_ptr  <= wr_ptr_nx;
            rd_data <= head_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the PC, addresses a combinational
// instruction ROM and queues {pc, insn} words toward decode through a
// 2-entry FIFO. Handles redirects (flush + refetch), halt/resume and a
// sticky fault on misaligned redirect targets.
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_addr / imem_insn : ROM byte address (= pc_q) / read data
//   out_valid/out_ready   : FIFO head handshake toward decode
//   out_pc / out_insn     : head entry (held while FIFO is empty)
//   redirect_valid/_pc    : taken branch/jump and its target
//   halt_req / halted     : level halt request / registered HALT indicator
//   fault / fault_pc      : sticky misaligned-redirect flag and its target
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    INSN_WIDTH = INSN_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INSN_WIDTH-1:0] imem_insn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INSN_WIDTH-1:0] out_insn,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  halted,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_pc
);

    fetch_state_e          state;
    logic [ADDR_WIDTH-1:0] pc_q;

    logic [1:0]            count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  misaligned;
    logic                  redirect_ok;
    logic                  redirect_bad;

    assign imem_addr  = pc_q;
    assign out_valid  = (count != 2'd0);
    assign pop        = ~empty & out_ready;
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    // BOOT ignores aligned redirects; any state but FAULT traps a misaligned one.
    assign redirect_ok  = redirect_valid & ~misaligned & ((state == RUN) | (state == HALT));
    assign redirect_bad = redirect_valid & misaligned & (state != FAULT);
    assign flush        = redirect_ok | redirect_bad;

    // A full FIFO can still accept a word when the head leaves this cycle.
    assign push = (state == RUN) & ~halt_req & ~redirect_valid & (~full | pop);

    fetch_fifo2 #(
        .WIDTH (ADDR_WIDTH + INSN_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data ({pc_q, imem_insn}),
        .rd_data ({out_pc, out_insn}),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc_q     <= RESET_PC;
            halted   <= 1'b0;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else if (redirect_bad) begin
            state    <= FAULT;
            halted   <= 1'b0;
            fault    <= 1'b1;
            fault_pc <= redirect_pc;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect_ok) begin
                        pc_q <= redirect_pc;
                    end else if (push) begin
                        pc_q <= pc_q + ADDR_WIDTH'(INSN_BYTES);
                    end
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (redirect_ok) begin
                        pc_q <= redirect_pc;
                    end
                    if (!halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    // FAULT is left only through reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  imem_addr;
    logic [31:0] imem_insn;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  out_pc;
    logic [31:0] out_insn;
    logic        redirect_valid = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        fault;
    logic [8:0]  fault_pc;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [8:0]  pc;
        logic [31:0] insn;
    } ent_t;

    // Reference model state (spec-level: fetch state, pc, queue of words owed to decode)
    ent_t       q[$];
    ent_t       last;
    int         mstate;
    logic [8:0] mpc;
    logic       mfault;
    logic [8:0] mfault_pc;

    function automatic logic [31:0] rom(input logic [8:0] a);
        return 32'h1000_0000 + 32'(a[8:2]);
    endfunction

    assign imem_insn = rom(imem_addr);

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_insn      (imem_insn),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_insn       (out_insn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        last      = '{pc: 9'h0, insn: 32'h0};
        mstate    = M_BOOT;
        mpc       = 9'h000;
        mfault    = 1'b0;
        mfault_pc = 9'h000;
    endfunction

    // One clock of the reference model; cnt0 is the number of words owed to
    // decode at the start of the cycle (the monitor has already retired a pop).
    function automatic void model_step(input int cnt0);
        bit took, push_ok, bad, good;
        took    = out_ready && (cnt0 > 0);
        bad     = redirect_valid && (redirect_pc[1:0] != 2'b00) && (mstate != M_FAULT);
        good    = redirect_valid && (redirect_pc[1:0] == 2'b00) && (mstate == M_RUN || mstate == M_HALT);
        push_ok = (mstate == M_RUN) && !halt_req && !redirect_valid && (cnt0 < 2 || took);
        if (bad || good) q.delete();
        if (push_ok) q.push_back('{pc: mpc, insn: rom(mpc)});
        if (bad) begin
            mstate    = M_FAULT;
            mfault    = 1'b1;
            mfault_pc = redirect_pc;
        end else begin
            case (mstate)
                M_BOOT: mstate = M_RUN;
                M_RUN: begin
                    if (good) mpc = redirect_pc;
                    else if (push_ok) mpc = 9'((int'(mpc) + 4) % 512);
                    if (halt_req) mstate = M_HALT;
                end
                M_HALT: begin
                    if (good) mpc = redirect_pc;
                    if (!halt_req) mstate = M_RUN;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic cycle(input bit rdy, input bit rv, input logic [8:0] rpc, input bit h);
        int cnt0;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = h;
        cnt0           = q.size();
        @(negedge clk);
        #1;
        model_step(cnt0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(rdy, 1'b0, 9'h000, 1'b0);
    endtask

    // Monitor: compares the DUT against the model every cycle and retires
    // the expected head whenever decode takes it.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("imem_addr", 64'(imem_addr), 64'(mpc));
            chk("halted", 64'(halted), 64'(mstate == M_HALT));
            chk("fault", 64'(fault), 64'(mfault));
            chk("fault_pc", 64'(fault_pc), 64'(mfault_pc));
            if (q.size() != 0) begin
                chk("out_pc", 64'(out_pc), 64'(q[0].pc));
                chk("out_insn", 64'(out_insn), 64'(q[0].insn));
                last = q[0];
                if (out_ready) void'(q.pop_front());
            end else begin
                chk("hold_pc", 64'(out_pc), 64'(last.pc));
                chk("hold_insn", 64'(out_insn), 64'(last.insn));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_pc", 64'(out_pc), 64'h0);
        chk("rst_out_insn", 64'(out_insn), 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_fault", 64'(fault), 64'h0);
        chk("rst_fault_pc", 64'(fault_pc), 64'h0);
        chk("rst_imem_addr", 64'(imem_addr), 64'h0);

        // Boot and stream
        idle(8, 1'b1);
        // Back-pressure then release
        idle(5, 1'b0);
        idle(5, 1'b1);
        // Fill, then redirect to 0x040 with a pop in the same cycle
        idle(3, 1'b0);
        cycle(1'b1, 1'b1, 9'h040, 1'b0);
        idle(4, 1'b1);
        // Halt for 4 cycles, then resume
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 9'h000, 1'b1);
        idle(4, 1'b1);
        // Wrap around the top of the address space
        cycle(1'b1, 1'b1, 9'h1F8, 1'b0);
        idle(6, 1'b1);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0,
                  9'($urandom_range(0, 127) * 4), ($urandom % 8) == 0);
        end
        idle(4, 1'b1);
        // Misaligned redirect traps; later redirects are ignored
        idle(2, 1'b0);
        cycle(1'b1, 1'b1, 9'h042, 1'b0);
        idle(3, 1'b1);
        cycle(1'b1, 1'b1, 9'h000, 1'b0);
        idle(3, 1'b1);
        chk("fault_sticky", 64'(fault), 64'h1);
        chk("fault_pc_kept", 64'(fault_pc), 64'h042);
        // Asynchronous reset mid-cycle clears fault
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_fault", 64'(fault), 64'h0);
        chk("mid_rst_fault_pc", 64'(fault_pc), 64'h0);
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        // Refill with decode stalled, then reset again while entries are held
        idle(4, 1'b0);
        chk("prefill_valid", 64'(out_valid), 64'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst2_valid", 64'(out_valid), 64'h0);
        chk("mid_rst2_out_pc", 64'(out_pc), 64'h0);
        chk("mid_rst2_imem_addr", 64'(imem_addr), 64'h0);
        idle(4, 1'b1);
        chk("queue_drained", 64'(q.size() <= 2), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
